// File: rtl/rk_spi_pkg.sv
// Shared constants for the SD-card SPI responder: idle byte, SD tokens,
// synchroniser depth and the frame-state encoding.
package rk_spi_pkg;
  localparam logic [7:0] SPI_IDLE_BYTE   = 8'hFF;
  localparam logic [7:0] R1_IDLE         = 8'h01;
  localparam logic [7:0] DATA_START      = 8'hFE;
  localparam int         SPI_SYNC_STAGES = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one SPI pin plus a history flop that turns the
// synchronised level into single-cycle rise/fall events.
module spi_edge_sync
  import rk_spi_pkg::*;
#(
  parameter int   STAGES     = SPI_SYNC_STAGES,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {STAGES{IDLE_LEVEL}};
      hist <= IDLE_LEVEL;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = sync[STAGES-1] & ~hist;
  assign fall  = ~sync[STAGES-1] & hist;

endmodule

// File: rtl/spi_sd_responder.sv
// SPI mode-0 target on the bit-banged SD port: oversamples CS/SCK/MOSI in the
// clk50 domain, delivers received bytes and shifts out agent-supplied responses.
module spi_sd_responder
  import rk_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       frame_start,
  output logic       tx_underrun,
  output logic       tx_overflow
);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs (
    .clk(clk50), .reset(reset), .pin(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck (
    .clk(clk50), .reset(reset), .pin(spi_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_mosi (
    .clk(clk50), .reset(reset), .pin(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = &{cs_level, sck_level, mosi_rise, mosi_fall};

  logic [0:0] state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] rx_shift, rx_shift_n, tx_shift, tx_shift_n, hold, hold_n;
  logic [7:0] rx_data_n;
  logic       tx_ready_n, miso_n, boundary;
  logic       rx_valid_n, frame_start_n, tx_underrun_n, tx_overflow_n;

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    rx_shift_n    = rx_shift;
    rx_data_n     = rx_data;
    tx_shift_n    = tx_shift;
    hold_n        = hold;
    tx_ready_n    = tx_ready;
    rx_valid_n    = 1'b0;
    frame_start_n = 1'b0;
    tx_underrun_n = 1'b0;
    tx_overflow_n = 1'b0;
    boundary      = 1'b0;

    if (cs_fall) begin
      state_n       = ST_ACTIVE;
      frame_start_n = 1'b1;
      bit_cnt_n     = 3'd0;
      boundary      = 1'b1;
    end else if (cs_rise) begin
      state_n    = ST_IDLE;
      bit_cnt_n  = 3'd0;
      tx_shift_n = IDLE_BYTE;
    end else if (state == ST_ACTIVE) begin
      if (sck_rise) begin
        rx_shift_n = {rx_shift[6:0], mosi_level};
        bit_cnt_n  = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_n  = rx_shift_n;
          rx_valid_n = 1'b1;
          boundary   = 1'b1;
        end
      end else if (sck_fall && bit_cnt != 3'd0) begin
        tx_shift_n = {tx_shift[6:0], 1'b1};
      end
    end

    // The boundary sees the holding register before any same-cycle tx_load.
    if (boundary) begin
      if (!tx_ready) begin
        tx_shift_n = hold;
        tx_ready_n = 1'b1;
      end else begin
        tx_shift_n    = IDLE_BYTE;
        tx_underrun_n = 1'b1;
      end
    end

    if (tx_load) begin
      if (tx_ready) begin
        hold_n     = tx_data;
        tx_ready_n = 1'b0;
      end else begin
        tx_overflow_n = 1'b1;
      end
    end

    miso_n = (state_n == ST_ACTIVE) ? tx_shift_n[7] : 1'b1;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= IDLE_BYTE;
      tx_shift    <= IDLE_BYTE;
      hold        <= IDLE_BYTE;
      rx_data     <= 8'h00;
      tx_ready    <= 1'b1;
      spi_miso    <= 1'b1;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      tx_underrun <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx_shift    <= rx_shift_n;
      tx_shift    <= tx_shift_n;
      hold        <= hold_n;
      rx_data     <= rx_data_n;
      tx_ready    <= tx_ready_n;
      spi_miso    <= miso_n;
      rx_valid    <= rx_valid_n;
      frame_start <= frame_start_n;
      tx_underrun <= tx_underrun_n;
      tx_overflow <= tx_overflow_n;
    end
  end

endmodule

// File: tb/tb_spi_sd_responder.sv
// Bench for spi_sd_responder: directed and randomized SPI frames checked
// against a byte-level model of the holding register and receive stream.
module tb_spi_sd_responder;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_load, tx_ready, frame_start, tx_underrun, tx_overflow;

  spi_sd_responder dut (
    .clk50(clk50), .reset(reset),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .frame_start(frame_start), .tx_underrun(tx_underrun), .tx_overflow(tx_overflow));

  always #10 clk50 = ~clk50;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_fs = 0, n_ur = 0, n_ov = 0, n_rxv = 0;
  int last_rx_cyc = 0, last_rise_cyc = 0;
  logic [7:0] rxq[$];

  always @(posedge clk50) cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (rx_valid) begin
      rxq.push_back(rx_data);
      n_rxv <= n_rxv + 1;
      last_rx_cyc <= cyc;
    end
    if (frame_start) n_fs <= n_fs + 1;
    if (tx_underrun) n_ur <= n_ur + 1;
    if (tx_overflow) n_ov <= n_ov + 1;
  end

  // Reference model: one-entry holding register, expected event counts and rx stream.
  bit         m_full = 1'b0;
  logic [7:0] m_val = 8'h00;
  int         exp_fs = 0, exp_ur = 0, exp_ov = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] cur_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic m_boundary(output logic [7:0] b);
    if (m_full) begin
      b = m_val;
      m_full = 1'b0;
    end else begin
      b = 8'hFF;
      exp_ur++;
    end
  endtask

  task automatic load_pulse(input logic [7:0] v);
    if (!m_full) begin
      m_full = 1'b1;
      m_val = v;
    end else begin
      exp_ov++;
    end
    tx_data = v;
    tx_load = 1'b1;
    step(1);
    tx_load = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] mo, input int nbits, input int nload,
                           input logic [7:0] l0, input logic [7:0] l1, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      step(20);
      spi_sck = 1'b1;
      mi[7-i] = spi_miso;
      last_rise_cyc = cyc;
      step(20);
      spi_sck = 1'b0;
      if (i == 3) begin
        if (nload > 0) load_pulse(l0);
        if (nload > 1) begin
          step(1);
          load_pulse(l1);
        end
      end
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    exp_fs++;
    m_boundary(cur_exp);
    step(20);
  endtask

  task automatic full_byte(input string tag, input logic [7:0] mo, input int nload,
                           input logic [7:0] l0, input logic [7:0] l1);
    logic [7:0] mi;
    send_bits(mo, 8, nload, l0, l1, mi);
    check({tag, "_miso"}, {24'h0, mi}, {24'h0, cur_exp});
    exp_rx.push_back(mo);
    m_boundary(cur_exp);
  endtask

  task automatic cs_high();
    step(10);
    spi_cs_n = 1'b1;
    step(10);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_rxcount"}, rxq.size(), exp_rx.size());
    while (exp_rx.size() > 0 && rxq.size() > 0)
      check({tag, "_rxdata"}, {24'h0, rxq.pop_front()}, {24'h0, exp_rx.pop_front()});
    rxq.delete();
    exp_rx.delete();
    check({tag, "_frame_start"}, n_fs, exp_fs);
    check({tag, "_underrun"}, n_ur, exp_ur);
    check({tag, "_overflow"}, n_ov, exp_ov);
  endtask

  initial begin
    logic [7:0] mi;
    int rx_before;
    reset = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b1;
    tx_load = 1'b0;
    tx_data = 8'h00;
    step(3);
    check("rst_miso", {31'h0, spi_miso}, 32'h1);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_frame_start", {31'h0, frame_start}, 32'h0);
    check("rst_underrun", {31'h0, tx_underrun}, 32'h0);
    check("rst_overflow", {31'h0, tx_overflow}, 32'h0);
    reset = 1'b0;
    step(5);

    // Single byte 0x40 with rx_valid latency.
    cs_low();
    full_byte("b40", 8'h40, 0, 8'h00, 8'h00);
    check("b40_latency", last_rx_cyc - last_rise_cyc, 3);
    cs_high();
    check_frame("b40");

    // Preloaded response 0xA5.
    load_pulse(8'hA5);
    check("a5_not_ready", {31'h0, tx_ready}, 32'h0);
    cs_low();
    check("a5_ready_after_cs", {31'h0, tx_ready}, 32'h1);
    full_byte("a5", 8'h00, 0, 8'h00, 8'h00);
    cs_high();
    check_frame("a5");

    // Two bytes with nothing queued.
    cs_low();
    full_byte("ff0", 8'h12, 0, 8'h00, 8'h00);
    full_byte("ff1", 8'h34, 0, 8'h00, 8'h00);
    cs_high();
    check_frame("ff");

    // Double load: second is ignored.
    load_pulse(8'h01);
    step(1);
    load_pulse(8'h02);
    cs_low();
    full_byte("ovf", 8'h77, 0, 8'h00, 8'h00);
    cs_high();
    check_frame("ovf");

    // Partial byte discarded, then 0x51.
    cs_low();
    send_bits(8'hA0, 3, 0, 8'h00, 8'h00, mi);
    cs_high();
    check("partial_miso_idle", {31'h0, spi_miso}, 32'h1);
    cs_low();
    full_byte("b51", 8'h51, 0, 8'h00, 8'h00);
    cs_high();
    check_frame("b51");

    // Reset mid-byte, then a clean 0x3C frame.
    load_pulse(8'h5A);
    cs_low();
    send_bits(8'hC3, 4, 1, 8'h66, 8'h00, mi);
    rx_before = n_rxv;
    reset = 1'b1;
    m_full = 1'b0;
    step(2);
    check("mid_rst_miso", {31'h0, spi_miso}, 32'h1);
    check("mid_rst_ready", {31'h0, tx_ready}, 32'h1);
    check("mid_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    spi_cs_n = 1'b1;
    reset = 1'b0;
    step(10);
    check("mid_rst_no_rx", n_rxv, rx_before);
    cs_low();
    full_byte("b3c", 8'h3C, 0, 8'h00, 8'h00);
    cs_high();
    check_frame("b3c");

    // Randomized frames with random loads before and during bytes.
    for (int r = 0; r < 10; r++) begin
      int pre = $urandom_range(0, 2);
      int nb = $urandom_range(1, 3);
      for (int k = 0; k < pre; k++) begin
        load_pulse(8'($urandom));
        step(1);
      end
      cs_low();
      for (int b = 0; b < nb; b++)
        full_byte("rnd", 8'($urandom), $urandom_range(0, 2), 8'($urandom), 8'($urandom));
      cs_high();
      check_frame("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
